// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone CPU master and its bus timer.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } wb_state_t;

  localparam int          TIMER_W          = 16;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

  // Increment that sticks at all-ones instead of wrapping back to zero
  function automatic logic [TIMER_W-1:0] sat_inc(input logic [TIMER_W-1:0] v);
    return (v == {TIMER_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_bus_timer.sv
// Saturating cycle counter that bounds a Wishbone cycle. expired is high in
// the BUS cycle that completes TIMEOUT cycles without a slave response.
module wb_bus_timer
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  // Count enabled cycles since the last clear, holding at the maximum value
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= sat_inc(count);
    end
  end

  // count holds the number of earlier BUS cycles, so LAST marks the final one
  assign expired = enable && (count >= LAST);

endmodule

// File: rtl/wb_cpu_master.sv
// Wishbone B3 classic master turning the CPU stall-based memory port into
// single bus cycles, each bounded by a timeout.
// Optional feature: define WB_CPU_MASTER_POSTED_WRITE_EN to let writes retire
// to the CPU one cycle after acceptance, with errors reported on post_err_o.
module wb_cpu_master
  import wb_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic [31:0] cpu_dat_o,
  output logic        cpu_pause_o,
  output logic        cpu_err_o,
  output logic        post_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

`ifdef WB_CPU_MASTER_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  wb_state_t state;
  logic      posted_q;
  logic      retire_q;
  logic      post_err_q;
  logic      expired;

  wb_bus_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_n_i(wb_rst_n_i),
    .clear     (state != BUS),
    .enable    (state == BUS),
    .expired   (expired)
  );

  // Access sequencer: latch the request, run one classic cycle, report back
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= IDLE;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      cpu_dat_o  <= '0;
      cpu_err_o  <= 1'b0;
      posted_q   <= 1'b0;
      retire_q   <= 1'b0;
      post_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_err_o <= 1'b0;
          if (cpu_req_i) begin
            state    <= BUS;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_adr_o <= cpu_adr_i;
            wb_dat_o <= cpu_dat_i;
            posted_q <= POSTED && cpu_we_i;
            retire_q <= POSTED && cpu_we_i;
          end
        end
        BUS: begin
          retire_q <= 1'b0;
          // Error (or timeout) takes priority over a simultaneous ack;
          // writes leave the CPU read data untouched either way.
          if (wb_err_i || expired) begin
            state    <= DONE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) cpu_dat_o <= ERR_DATA;
            if (posted_q) post_err_q <= 1'b1;
            else          cpu_err_o  <= 1'b1;
          end else if (wb_ack_i) begin
            state    <= DONE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (!wb_we_o) cpu_dat_o <= wb_dat_i;
          end
        end
        DONE: begin
          state     <= IDLE;
          cpu_err_o <= 1'b0;
          posted_q  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
      endcase
    end
  end

  // Stall the CPU until DONE, except around a posted write, whose DONE keeps
  // pause up and whose first BUS cycle releases it to retire the write early
  always_comb begin
    cpu_pause_o = cpu_req_i && !((state == DONE) && !posted_q) && !retire_q;
  end

  assign post_err_o = post_err_q;

endmodule
